step_sequencer: RTL and testbench
=================================

# step_sequencer

Generates the 2-bit select that drives the 2-to-4 one-hot decoder stage. A raw pushbutton is synchronised and debounced, and each clean press advances the select by one, up or down, wrapping modulo 4. An optional auto-scan mode advances the select from a free-running prescaler. Outputs `out1`/`out0` connect directly to the decoder's `in1`/`in0`.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronised samples needed to accept a level change. Legal range is 2 or more.
- `SCAN_DIV`, default 8: clock cycles per auto-scan step. Legal range is 2 or more.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `btn`  in  1  raw pushbutton, asynchronous to `clk`, may bounce.
- `auto_en`  in  1  synchronous; 1 enables auto-scan stepping.
- `dir`  in  1  synchronous; 0 means +1 per step, 1 means −1 per step.
- `out1`  out  1  select MSB, to decoder `in1`.
- `out0`  out  1  select LSB, to decoder `in0`.
- `step_pulse`  out  1  high for exactly the one cycle in which a new select value first appears.

## Operation
- **Reset values** (async `rst`=1, held while `rst`=1):
  - both synchroniser flops 0
  - debounce FSM IDLE_LOW, debounce counter 0
  - prescaler 0
  - `{out1,out0}`=00, `step_pulse`=0
  - The decoder therefore sees out0-hot.
- **Synchroniser:** two flops, `btn` → s1 → s2. Only s2 is used downstream.
- **Debounce FSM** (4 states, counter width ≥ clog2(`DEBOUNCE_CYCLES`)):
  - IDLE_LOW: s2=1 → WAIT_HIGH, cnt←1; else stay.
  - WAIT_HIGH: s2=0 → IDLE_LOW, cnt←0. s2=1 and cnt=`DEBOUNCE_CYCLES`−1 → IDLE_HIGH, cnt←0, raise press event. Otherwise cnt←cnt+1.
  - IDLE_HIGH: s2=0 → WAIT_LOW, cnt←1; else stay.
  - WAIT_LOW: s2=1 → IDLE_HIGH, cnt←0. s2=0 and cnt=`DEBOUNCE_CYCLES`−1 → IDLE_LOW, cnt←0, no event. Otherwise cnt←cnt+1.
  - A step is generated only on the WAIT_HIGH→IDLE_HIGH transition. Release never steps.
- **Auto-scan prescaler:**
  - `auto_en`=0: prescaler←0.
  - `auto_en`=1: prescaler increments; at `SCAN_DIV`−1 it wraps to 0 and raises a tick event.
- **Step logic:**
  - step = press event OR tick event. A press and a tick on the same edge produce exactly one step.
  - On a step: sel←sel+1 (`dir`=0) or sel−1 (`dir`=1), 2-bit modulo arithmetic (11+1=00, 00−1=11). `dir` is sampled on the step edge.
  - `step_pulse`←1 on the step edge, 0 on all other edges.
- `out1`/`out0`/`step_pulse` are registered, with no combinational path from any input.

## Timing
- **Press latency:** `btn` first sampled high at edge k (s1). Then:
  - s2 is high after edge k+1.
  - WAIT_HIGH is entered at k+2.
  - sel updates and `step_pulse` rises at edge k+1+`DEBOUNCE_CYCLES`. With default 4, that is k+5.
- Any s2=0 sample during WAIT_HIGH aborts the press; the full count restarts on the next high sample.
- **Auto-scan:** with `auto_en` sampled high at edge j and the prescaler at 0, the first step occurs at edge j+`SCAN_DIV`−1, then every `SCAN_DIV` edges.
- Deasserting `auto_en` clears the prescaler on the next edge and no tick is produced. Re-enabling restarts the full period.
- **Reset mid-operation:** all state returns to reset values immediately. If `btn` is still held when `rst` falls, that counts as a fresh press: one step at edge r+1+`DEBOUNCE_CYCLES`, where r is the first edge after `rst` falls.
- Minimum spacing between two press steps: 2·`DEBOUNCE_CYCLES` edges.

## Test plan
- **Reset:** assert `rst` mid-cycle → `{out1,out0}`=00 and `step_pulse`=0 immediately, without waiting for a clock edge. Release `rst` and idle 20 cycles → still 00, no pulse.
- **Clean press** (defaults): `btn` high for 12 cycles from edge k, then low for 12 → exactly one step 00→01 at edge k+5, `step_pulse` high that one cycle only, no change on release.
- **Bounce rejection:** `btn` pattern high 3, low 1, high 3, low 6 → no step. Then high 10 → one step 01→10 at the 5th edge after that run starts.
- **Wrap and direction:** from 00 with `dir`=0, four clean presses → 01, 10, 11, 00. Then `dir`=1, one press → 11. Then `dir`=1, one press → 10.
- **Auto-scan:** `auto_en`=1 for 32 cycles from 00 → steps exactly every 8 edges (01, 10, 11, 00). Arrange for a debounced press to complete on the same edge as a tick → a single +1 step only.
- **Reset mid-debounce:** `btn` held, `rst` pulsed while in WAIT_HIGH → 00 immediately. With `btn` still held after `rst` falls → exactly one step to 01 at edge r+5, and no further steps.

Source files
------------

// File: rtl/step_sequencer_if.sv
// Pushbutton/auto-scan controls in, decoder select and step strobe out.
interface step_sequencer_if;
  logic btn;
  logic auto_en;
  logic dir;
  logic out1;
  logic out0;
  logic step_pulse;

  modport master (output btn, auto_en, dir, input out1, out0, step_pulse);
  modport slave  (input btn, auto_en, dir, output out1, out0, step_pulse);
endinterface

// File: rtl/step_sequencer.sv
// Debounced pushbutton / auto-scan stepper producing a 2-bit select for a
// 2-to-4 one-hot decoder, wrapping modulo 4 in either direction.
module step_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned SCAN_DIV        = 8
) (
  input  logic             clk,
  input  logic             rst,
  step_sequencer_if.slave  bus
);

  localparam int unsigned CNT_W = ($clog2(DEBOUNCE_CYCLES) > 0) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned PRE_W = ($clog2(SCAN_DIV) > 0) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } db_state_t;

  logic             s1_q, s2_q;
  db_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PRE_W-1:0] presc_q;
  logic [1:0]       sel_q;
  logic             pulse_q;
  logic             press_c;
  logic             tick_c;
  logic             cnt_done_c;

  // Two-flop synchroniser for the asynchronous button
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= bus.btn;
      s2_q <= s1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cnt_done_c = (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

  // Debounce next-state; only a qualified rising level raises a press
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_c = 1'b0;
    unique case (state_q)
      IDLE_LOW: begin
        if (s2_q) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT_HIGH: begin
        if (!s2_q) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_done_c) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
          press_c = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      IDLE_HIGH: begin
        if (!s2_q) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT_LOW: begin
        if (s2_q) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_done_c) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  assign tick_c = bus.auto_en && (presc_q == PRE_W'(SCAN_DIV - 1));

  // Free-running auto-scan prescaler, held clear while disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
    end else if (!bus.auto_en || tick_c) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PRE_W'(1);
    end
  end

  // Coincident press and tick merge into a single step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q   <= 2'b00;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= press_c || tick_c;
      if (press_c || tick_c) begin
        sel_q <= bus.dir ? (sel_q - 2'd1) : (sel_q + 2'd1);
      end
    end
  end

  assign bus.out1       = sel_q[1];
  assign bus.out0       = sel_q[0];
  assign bus.step_pulse = pulse_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Scoreboard bench for step_sequencer: a debounce/auto-scan reference model
// predicts every step; a negedge monitor checks pulses and select values.
module tb_step_sequencer;

  localparam int unsigned DB  = 4;
  localparam int unsigned DIV = 8;

  typedef struct {
    int         cyc;
    logic [1:0] sel;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  step_sequencer_if bus ();

  step_sequencer #(.DEBOUNCE_CYCLES(DB), .SCAN_DIV(DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  exp_t exp_q[$];

  // Reference model: button level accepted after DB consecutive differing
  // synchronised samples; auto tick every DIV-th consecutive enabled edge.
  initial begin : model
    logic       h1, h2, s2v, lvl, press, tick;
    int         run, en_run;
    logic [1:0] m_sel;
    exp_t       e;
    h1 = 0; h2 = 0; lvl = 0; run = 0; en_run = 0; m_sel = 2'b00;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        h1 = 0; h2 = 0; lvl = 0; run = 0; en_run = 0; m_sel = 2'b00;
        exp_q.delete();
      end else begin
        cyc++;
        press = 1'b0;
        tick  = 1'b0;
        s2v = h2;
        h2  = h1;
        h1  = bus.btn;
        if (s2v != lvl) begin
          run++;
          if (run == int'(DB)) begin
            lvl   = s2v;
            run   = 0;
            press = s2v;
          end
        end else begin
          run = 0;
        end
        if (bus.auto_en) begin
          en_run++;
          tick = ((en_run % int'(DIV)) == 0);
        end else begin
          en_run = 0;
        end
        if (press || tick) begin
          m_sel = bus.dir ? (m_sel - 2'd1) : (m_sel + 2'd1);
          e.cyc = cyc;
          e.sel = m_sel;
          exp_q.push_back(e);
        end
      end
    end
  end

  // Monitor: pulse must match a predicted step; select must hold otherwise
  initial begin : monitor
    logic [1:0] cur, prev;
    logic       exp_now;
    exp_t       e;
    prev = 2'b00;
    forever begin
      @(negedge clk);
      cur = {bus.out1, bus.out0};
      if (rst) begin
        prev = 2'b00;
      end else begin
        exp_now = (exp_q.size() != 0) && (exp_q[0].cyc == cyc);
        compared++;
        if (bus.step_pulse !== exp_now) begin
          mismatched++;
          $display("FAIL step_pulse cyc=%0d got=%b expected=%b", cyc, bus.step_pulse, exp_now);
        end
        if (exp_now) begin
          e = exp_q.pop_front();
          compared++;
          if (cur !== e.sel) begin
            mismatched++;
            $display("FAIL step_sel cyc=%0d got=%b expected=%b", cyc, cur, e.sel);
          end
        end else begin
          compared++;
          if (cur !== prev) begin
            mismatched++;
            $display("FAIL sel_hold cyc=%0d got=%b expected=%b", cyc, cur, prev);
          end
        end
        prev = cur;
      end
    end
  end

  task automatic chk(input string name, input logic [2:0] got, input logic [2:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s got=%b expected=%b", name, got, want);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_once();
    bus.btn = 1'b1;
    cycles(10);
    bus.btn = 1'b0;
    cycles(10);
  endtask

  // Asynchronous reset pulse asserted away from any clock edge
  task automatic pulse_reset(input string name);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk(name, {bus.step_pulse, bus.out1, bus.out0}, 3'b000);
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin : stim
    bus.btn = 1'b0;
    bus.auto_en = 1'b0;
    bus.dir = 1'b0;

    cycles(2);
    chk("reset_hold", {bus.step_pulse, bus.out1, bus.out0}, 3'b000);
    #2 rst = 1'b0;
    cycles(20);
    chk("idle_after_reset", {bus.step_pulse, bus.out1, bus.out0}, 3'b000);

    // Clean press, then release
    bus.btn = 1'b1; cycles(12);
    bus.btn = 1'b0; cycles(12);
    chk("clean_press", {1'b0, bus.out1, bus.out0}, 3'b001);

    // Bounce rejection followed by a genuine press
    bus.btn = 1'b1; cycles(3);
    bus.btn = 1'b0; cycles(1);
    bus.btn = 1'b1; cycles(3);
    bus.btn = 1'b0; cycles(6);
    chk("bounce_reject", {1'b0, bus.out1, bus.out0}, 3'b001);
    bus.btn = 1'b1; cycles(10);
    bus.btn = 1'b0; cycles(12);
    chk("after_bounce", {1'b0, bus.out1, bus.out0}, 3'b010);

    // Wrap and direction
    press_once(); press_once();
    chk("back_to_00", {1'b0, bus.out1, bus.out0}, 3'b000);
    press_once(); chk("wrap_01", {1'b0, bus.out1, bus.out0}, 3'b001);
    press_once(); chk("wrap_10", {1'b0, bus.out1, bus.out0}, 3'b010);
    press_once(); chk("wrap_11", {1'b0, bus.out1, bus.out0}, 3'b011);
    press_once(); chk("wrap_00", {1'b0, bus.out1, bus.out0}, 3'b000);
    bus.dir = 1'b1;
    press_once(); chk("down_11", {1'b0, bus.out1, bus.out0}, 3'b011);
    press_once(); chk("down_10", {1'b0, bus.out1, bus.out0}, 3'b010);
    bus.dir = 1'b0;

    // Auto-scan for four full periods from 00
    pulse_reset("reset_before_auto");
    cycles(3);
    bus.auto_en = 1'b1; cycles(32);
    bus.auto_en = 1'b0; cycles(5);
    chk("auto_32", {1'b0, bus.out1, bus.out0}, 3'b000);

    // Press completing on the same edge as the first tick
    bus.auto_en = 1'b1; cycles(2);
    bus.btn = 1'b1;     cycles(6);
    bus.auto_en = 1'b0; cycles(10);
    bus.btn = 1'b0;     cycles(12);
    chk("press_tick_merge", {1'b0, bus.out1, bus.out0}, 3'b001);

    // Randomised bouncing button, direction and auto-scan
    for (int i = 0; i < 40; i++) begin
      bus.dir     = 1'($urandom_range(0, 1));
      bus.auto_en = ($urandom_range(0, 3) == 0);
      bus.btn     = ~bus.btn;
      cycles($urandom_range(1, 12));
    end
    bus.auto_en = 1'b0;
    bus.btn = 1'b0;
    cycles(15);

    // Reset while the press is being debounced, button still held
    bus.dir = 1'b0;
    bus.btn = 1'b1;
    cycles(3);
    pulse_reset("reset_mid_debounce");
    cycles(20);
    chk("press_after_reset", {1'b0, bus.out1, bus.out0}, 3'b001);
    bus.btn = 1'b0;
    cycles(12);
    chk("no_extra_step", {1'b0, bus.out1, bus.out0}, 3'b001);

    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL pending_steps got=%0d expected=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
